// File: rtl/alu_iterative.sv
// alu_iterative: multi-cycle execution unit for the 4-bit ALUControl encoding.
//
// Ports:
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready   request handshake; in_ready is high only in IDLE
//   alu_ctrl            operation code
//   op_a, op_b          operands; op_b[SHW-1:0] is the shift amount for shifts
//   out_valid/out_ready result handshake; out_valid held until out_ready
//   result, zero        registered result and (result == 0)
//   illegal             registered, alu_ctrl was not a defined code
//
// Logic/arithmetic ops complete on the accept edge. Shifts move one bit per
// cycle. The first bit is shifted on the accept edge itself, so a shift by
// N presents its result N cycles after accept (1 cycle for N = 0 or 1).
module alu_iterative #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             left_q, left_d;
  logic             arith_q, arith_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

  logic             is_shift;
  logic             req_left;
  logic             req_arith;
  logic [SHW-1:0]   shamt;
  logic             long_shift;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] acc_step;

  // One-bit shift step; a right shift fills with the sign bit when arith is set.
  function automatic logic [WIDTH-1:0] shift1(input logic [WIDTH-1:0] v,
                                              input logic left,
                                              input logic arith);
    if (left) return {v[WIDTH-2:0], 1'b0};
    return {arith & v[WIDTH-1], v[WIDTH-1:1]};
  endfunction

  // Decode and single-cycle results. For shifts, alu_res covers the
  // amounts (0 and 1) that finish on the accept edge.
  always_comb begin
    is_shift   = (alu_ctrl == OP_SLL) || (alu_ctrl == OP_SRL) || (alu_ctrl == OP_SRA);
    req_left   = (alu_ctrl == OP_SLL);
    req_arith  = (alu_ctrl == OP_SRA);
    shamt      = op_b[SHW-1:0];
    long_shift = is_shift && (shamt > SHW'(1));
    alu_res    = '0;
    alu_ill    = 1'b0;
    case (alu_ctrl)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_AND:  alu_res = op_a & op_b;
      OP_OR:   alu_res = op_a | op_b;
      OP_XOR:  alu_res = op_a ^ op_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
      OP_SLL, OP_SRL, OP_SRA:
        alu_res = (shamt == '0) ? op_a : shift1(op_a, req_left, req_arith);
      default: alu_ill = 1'b1;
    endcase
  end

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      left_q    <= 1'b0;
      arith_q   <= 1'b0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      left_q    <= left_d;
      arith_q   <= arith_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = long_shift ? SHIFT : DONE;
      SHIFT:   if (cnt_q == SHW'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs, decoded from state only.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Datapath next values; everything holds unless updated below.
  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    left_d    = left_q;
    arith_d   = arith_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    acc_step  = shift1(acc_q, left_q, arith_q);
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (long_shift) begin
            // First bit goes on the accept edge; cnt tracks the remaining bits.
            acc_d   = shift1(op_a, req_left, req_arith);
            cnt_d   = shamt - SHW'(1);
            left_d  = req_left;
            arith_d = req_arith;
          end else begin
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = alu_ill;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_step;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) begin
          result_d  = acc_step;
          zero_d    = (acc_step == '0);
          illegal_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign result  = result_q;
  assign zero    = zero_q;
  assign illegal = illegal_q;

endmodule
